vga_scan_arbiter: RTL
=====================

VGA_SCAN_ARBITER -- requirements
Module: vga_scan_arbiter

Interface
REQ-001 Parameter H_VIS, 640, visible pixels per line; H_FP 16, H_SYNC 96, H_BP 48 (H total 800).
REQ-002 Parameter V_VIS, 480, visible lines; V_FP 10, V_SYNC 2, V_BP 33 (V total 525).
REQ-003 Parameter FB_W, 160, framebuffer tiles per row; FB_H 120, tile rows; each tile covers 4x4 pixels.
REQ-004 CLK_IN  in  1  system clock, 50 MHz.
REQ-005 RST_N  in  1  asynchronous, active-low reset.
REQ-006 WR_REQ  in  1  writer request, held high until WR_ACK.
REQ-007 WR_ADDR  in  15  writer tile address, row-major.
REQ-008 WR_DATA  in  3  writer colour {R,G,B}.
REQ-009 WR_ACK  out  1  one-cycle grant/completion pulse.
REQ-010 MEM_ADDR  out  15  framebuffer address (combinational).
REQ-011 MEM_WE  out  1  framebuffer write enable (combinational).
REQ-012 MEM_WDATA  out  3  framebuffer write data.
REQ-013 MEM_RDATA  in  3  framebuffer read data, valid one cycle after address (synchronous RAM).
REQ-014 HSYNC, VSYNC  out  1 each  active-low syncs, registered.
REQ-015 R, G, B  out  1 each  pixel colour, registered.
REQ-016 FRAME_START  out  1  one-cycle pulse per frame.

Function
REQ-017 1-bit phase toggles every CLK_IN cycle; pix_en = (phase==1); 25 MHz pixel rate.
REQ-018 h counter 0..799 increments on pix_en, wraps to 0; v counter increments when h wraps, 0..524, wraps to 0.
REQ-019 visible = (h<640)&&(v<480); tile address = (v>>2)*160 + (h>>2), computed in 15 bits.
REQ-020 Phase 0, visible: display owns memory; MEM_ADDR = tile address, MEM_WE=0; writer not granted.
REQ-021 Phase 1, or phase 0 while not visible: if WR_REQ, writer granted: MEM_ADDR=WR_ADDR, MEM_WDATA=WR_DATA, WR_ACK=1 that cycle.
REQ-022 Granted write with WR_ADDR >= 19200: WR_ACK=1, MEM_WE=0 (dropped, no memory access); otherwise MEM_WE=1.
REQ-023 Writer must not see two ACKs for one request; WR_REQ deasserted the cycle after ACK or a new request is assumed.
REQ-024 On pix_en edge: {R,G,B} <= visible ? MEM_RDATA : 3'b000; HSYNC <= !(656<=h<752); VSYNC <= !(490<=v<492).
REQ-025 Hence outputs for pixel (h,v) are held for the 2-cycle period following its pix_en edge; colour and syncs always aligned.
REQ-026 FRAME_START=1 for exactly the one cycle following the pix_en edge where (h,v) transitions (799,524)->(0,0).
REQ-027 WR_REQ arriving in visible phase 0: ACK in the immediately following cycle (max wait 1 cycle); in blanking: ACK same cycle.
REQ-028 No display read is ever displaced by a write; display reads during blanking are not issued.

Reset
REQ-029 RST_N low: phase=0, h=0, v=0, HSYNC=1, VSYNC=1, R=G=B=0, FRAME_START=0.
REQ-030 RST_N low forces WR_ACK=0 and MEM_WE=0 combinationally, including mid-request; pending request is re-arbitrated after release.
REQ-031 First pix_en edge occurs at the second rising edge after RST_N release.

Verification
REQ-032 Free run after reset -> HSYNC low 192 cycles every 1600; VSYNC low 3200 cycles every 840000; FRAME_START period 840000.
REQ-033 Preload tile 0 = 3'b101, tile 1 = 3'b010 -> pixels h=0..3, v=0..3 output R=1,G=0,B=1; h=4..7 output G=1 only; blanking output 000.
REQ-034 WR_REQ rises in visible phase 0 with WR_ADDR=5, WR_DATA=3'b111 -> next cycle WR_ACK=1, MEM_WE=1, MEM_ADDR=5; display read unaffected.
REQ-035 WR_REQ in vertical blanking, phase 0 -> WR_ACK and MEM_WE same cycle.
REQ-036 WR_REQ with WR_ADDR=19200 -> WR_ACK=1, MEM_WE=0 throughout.
REQ-037 Assert RST_N low mid-line during granted write -> WR_ACK, MEM_WE drop immediately; outputs return to reset values; timing restarts at (0,0).

Source files
------------

// File: rtl/vga_scan_arbiter_if.sv
// Writer handshake and framebuffer port shared by the scan arbiter and its environment.
// The slave side is the arbiter; the master side is the writer plus the RAM.
interface vga_scan_arbiter_if;
    logic        wr_req;
    logic [14:0] wr_addr;
    logic [2:0]  wr_data;
    logic        wr_ack;
    logic [14:0] mem_addr;
    logic        mem_we;
    logic [2:0]  mem_wdata;
    logic [2:0]  mem_rdata;

    modport master (
        output wr_req, wr_addr, wr_data, mem_rdata,
        input  wr_ack, mem_addr, mem_we, mem_wdata
    );

    modport slave (
        input  wr_req, wr_addr, wr_data, mem_rdata,
        output wr_ack, mem_addr, mem_we, mem_wdata
    );
endinterface

// File: rtl/vga_scan_arbiter.sv
// VGA timing generator that shares a single-port tile framebuffer between the display scan
// (visible phase-0 slots) and a writer (every other slot).
module vga_scan_arbiter #(
    parameter int unsigned H_VIS  = 640,
    parameter int unsigned H_FP   = 16,
    parameter int unsigned H_SYNC = 96,
    parameter int unsigned H_BP   = 48,
    parameter int unsigned V_VIS  = 480,
    parameter int unsigned V_FP   = 10,
    parameter int unsigned V_SYNC = 2,
    parameter int unsigned V_BP   = 33,
    parameter int unsigned FB_W   = 160,
    parameter int unsigned FB_H   = 120
) (
    input  logic               clk,
    input  logic               rst_n,
    vga_scan_arbiter_if.slave  bus,
    output logic               hsync,
    output logic               vsync,
    output logic               r,
    output logic               g,
    output logic               b,
    output logic               frame_start
);

    localparam int unsigned H_TOTAL = H_VIS + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL = V_VIS + V_FP + V_SYNC + V_BP;

    localparam logic [9:0]  H_LAST   = 10'(H_TOTAL - 1);
    localparam logic [9:0]  V_LAST   = 10'(V_TOTAL - 1);
    localparam logic [9:0]  H_VIS_W  = 10'(H_VIS);
    localparam logic [9:0]  V_VIS_W  = 10'(V_VIS);
    localparam logic [9:0]  HS_START = 10'(H_VIS + H_FP);
    localparam logic [9:0]  HS_END   = 10'(H_VIS + H_FP + H_SYNC);
    localparam logic [9:0]  VS_START = 10'(V_VIS + V_FP);
    localparam logic [9:0]  VS_END   = 10'(V_VIS + V_FP + V_SYNC);
    localparam logic [14:0] FB_W_W   = 15'(FB_W);
    localparam logic [14:0] FB_SIZE  = 15'(FB_W * FB_H);

    logic        phase_q;
    logic [9:0]  h_q;
    logic [9:0]  v_q;
    logic [2:0]  rgb_q;
    logic        hsync_q;
    logic        vsync_q;
    logic        frame_start_q;

    logic        pix_en;
    logic        visible;
    logic        display_slot;
    logic        grant;
    logic [14:0] tile_addr;

    assign pix_en       = phase_q;
    assign visible      = (h_q < H_VIS_W) && (v_q < V_VIS_W);
    assign display_slot = !phase_q && visible;
    assign tile_addr    = 15'(v_q >> 2) * FB_W_W + 15'(h_q >> 2);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase_q <= 1'b0;
            h_q     <= '0;
            v_q     <= '0;
        end else begin
            phase_q <= ~phase_q;
            if (pix_en) begin
                if (h_q == H_LAST) begin
                    h_q <= '0;
                    v_q <= (v_q == V_LAST) ? '0 : v_q + 10'd1;
                end else begin
                    h_q <= h_q + 10'd1;
                end
            end
        end
    end

    // RAM data for the phase-0 read is valid during phase 1, so it is captured on pix_en
    // together with the syncs of the same pixel.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rgb_q         <= 3'b000;
            hsync_q       <= 1'b1;
            vsync_q       <= 1'b1;
            frame_start_q <= 1'b0;
        end else begin
            frame_start_q <= pix_en && (h_q == H_LAST) && (v_q == V_LAST);
            if (pix_en) begin
                rgb_q   <= visible ? bus.mem_rdata : 3'b000;
                hsync_q <= !((h_q >= HS_START) && (h_q < HS_END));
                vsync_q <= !((v_q >= VS_START) && (v_q < VS_END));
            end
        end
    end

    // Reset gates the grant combinationally so a held request is dropped mid-cycle.
    assign grant = rst_n && bus.wr_req && !display_slot;

    always_comb begin
        bus.wr_ack    = grant;
        bus.mem_we    = grant && (bus.wr_addr < FB_SIZE);
        bus.mem_addr  = grant ? bus.wr_addr : tile_addr;
        bus.mem_wdata = bus.wr_data;
    end

    assign hsync       = hsync_q;
    assign vsync       = vsync_q;
    assign r           = rgb_q[2];
    assign g           = rgb_q[1];
    assign b           = rgb_q[0];
    assign frame_start = frame_start_q;

endmodule
